// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32I fetch PC register and instruction-memory request sequencer
// Optional feature macro PC_MISALIGN_TRAP_EN: misaligned redirect targets enter a sticky TRAP state.
// Without it, redirect targets are word-aligned by clearing bits [1:0] and misalign_o is tied low.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] newpc_i,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        imem_req_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_t;
    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_q;
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif
    assign imem_req_o    = req_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    // Fetch FSM: priority rst > redirect > stall > handshake; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH, HOLD: begin
                    if (branch_taken_i) begin
                        instr_q <= NOP_INSTR;
`ifdef PC_MISALIGN_TRAP_EN
                        pc_q    <= newpc_i;
                        if (newpc_i[1:0] != 2'b00) begin
                            state_q    <= TRAP;
                            req_q      <= 1'b0;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                        end
`else
                        pc_q    <= newpc_i & ~32'h3;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
`endif
                    end else if (stall_i) begin
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                    end else if (state_q == HOLD) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end else if (imem_ready_i) begin
                        instr_q <= imem_rdata_i;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                default: req_q <= 1'b0;
            endcase
        end
    end
    // The fetch address stays word aligned unless the core is parked in TRAP.
    a_pc_aligned: assert property (@(posedge clk) disable iff (rst)
        (state_q != TRAP) |-> (pc_q[1:0] == 2'b00));
    // A fresh instruction is only presented while the fetch request remains asserted.
    a_valid_in_fetch: assert property (@(posedge clk) disable iff (rst)
        valid_q |-> req_q);
endmodule
